// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin search used by the FIFO write-side arbiter.
package fifo_arb_pkg;

   typedef enum logic {ARB_IDLE = 1'b0, ARB_OWN = 1'b1} arb_state_t;

   // Requester count is capped at 16, so the search works on 16-bit/4-bit views.
   typedef struct packed {
      logic       vld;
      logic [3:0] idx;
   } rr_res_t;

   // Scan last+1, last+2, ... (mod n), with last itself as the final candidate.
   // The loop runs downward so the nearest candidate is the last one to overwrite.
   function automatic rr_res_t rr_next(input logic [15:0] req, input logic [3:0] last,
                                       input int n);
      rr_res_t r;
      int      k;
      r = '0;
      for (int i = 16; i >= 1; i--) begin
         if (i <= n) begin
            k = int'(last) + i;
            if (k >= n) k = k - n;  // explicit wrap keeps odd counts in range
            if (req[k[3:0]]) begin
               r.vld = 1'b1;
               r.idx = k[3:0];
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector shared by IDLE entry and OWN release.
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  last,
   output logic [IDW-1:0]  idx,
   output logic            vld
);

   rr_res_t res;

   // Widen to the package's fixed 16-requester view, then narrow the result.
   always_comb begin
      res = rr_next(16'(req), 4'(last), NREQ);
      idx = IDW'(res.idx);
      vld = res.vld;
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NREQ requesters,
// with bounded bursts, wfull gating and source tagging of every word.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int DSIZE    = 8,
   parameter int MAXBURST = 4,
   parameter int IDW      = $clog2(NREQ)
) (
   input  logic                  wclk,
   input  logic                  wrst_n,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*DSIZE-1:0] req_data,
   output logic [NREQ-1:0]       ack,
   input  logic                  wfull,
   output logic                  winc,
   output logic [DSIZE-1:0]      wdata,
   output logic [IDW-1:0]        wsrc,
   output logic [NREQ-1:0]       gnt,
   output logic                  busy
);

   localparam int             BW       = $clog2(MAXBURST + 1);
   localparam logic [BW-1:0]  BLAST    = BW'(MAXBURST - 1);
   localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);

   arb_state_t     state, state_nxt;
   logic [IDW-1:0] owner, owner_nxt, last, last_nxt;
   logic [IDW-1:0] pick_last, pick_idx;
   logic [BW-1:0]  bcnt, bcnt_nxt;
   logic           own, owner_req, rel, pick_vld;

   assign own       = (state == ARB_OWN);
   assign owner_req = req[owner];
   assign winc      = own & owner_req & ~wfull;
   // Release on the final write of a burst, or when the owner withdraws.
   assign rel       = own & ((winc & (bcnt == BLAST)) | ~owner_req);
   // At release the owner becomes 'last', so it ranks last in the re-pick.
   assign pick_last = rel ? owner : last;

   assign busy  = own;
   assign gnt   = own  ? (NREQ'(1) << owner) : '0;
   assign ack   = winc ? (NREQ'(1) << owner) : '0;
   assign wsrc  = own  ? owner : '0;
   assign wdata = own  ? req_data[int'(owner)*DSIZE +: DSIZE] : '0;

   rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
      .req  (req),
      .last (pick_last),
      .idx  (pick_idx),
      .vld  (pick_vld)
   );

   // State registers; reset leaves requester 0 with first priority.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         state <= ARB_IDLE;
         owner <= '0;
         last  <= LAST_RST;
         bcnt  <= '0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
         last  <= last_nxt;
         bcnt  <= bcnt_nxt;
      end
   end

   // Next owner/burst count: grant from IDLE, count writes, hand over on release.
   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      last_nxt  = last;
      bcnt_nxt  = bcnt;
      case (state)
         ARB_IDLE: begin
            if (pick_vld) begin
               state_nxt = ARB_OWN;
               owner_nxt = pick_idx;
               bcnt_nxt  = '0;
            end
         end
         ARB_OWN: begin
            if (winc) bcnt_nxt = bcnt + 1'b1;
            if (rel) begin
               last_nxt = owner;
               bcnt_nxt = '0;
               if (pick_vld) owner_nxt = pick_idx;
               else          state_nxt = ARB_IDLE;
            end
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench: a 4-requester instance (MAXBURST=4) and a 3-requester
// instance (MAXBURST=3), both compared each cycle against a behavioural model.
module tb_fifo_wr_arbiter;

   logic        wclk = 1'b0;
   logic        wrst_n;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  ack, gnt;
   logic        wfull, winc, busy;
   logic [7:0]  wdata;
   logic [1:0]  wsrc;

   logic [2:0]  reqb, ackb, gntb;
   logic [23:0] req_datab;
   logic        winc_b, busy_b;
   logic [7:0]  wdata_b;
   logic [1:0]  wsrc_b;

   int nvec = 0;
   int nerr = 0;

   typedef struct {
      bit own;
      int owner;
      int last;
      int bcnt;
   } mdl_t;

   mdl_t ma, mb;

   always #5 wclk = ~wclk;

   fifo_wr_arbiter #(.NREQ(4), .DSIZE(8), .MAXBURST(4)) dut_a (
      .wclk(wclk), .wrst_n(wrst_n), .req(req), .req_data(req_data), .ack(ack),
      .wfull(wfull), .winc(winc), .wdata(wdata), .wsrc(wsrc), .gnt(gnt), .busy(busy)
   );

   fifo_wr_arbiter #(.NREQ(3), .DSIZE(8), .MAXBURST(3)) dut_b (
      .wclk(wclk), .wrst_n(wrst_n), .req(reqb), .req_data(req_datab), .ack(ackb),
      .wfull(wfull), .winc(winc_b), .wdata(wdata_b), .wsrc(wsrc_b), .gnt(gntb), .busy(busy_b)
   );

   // ---------------- reference model ----------------
   function automatic mdl_t mreset(input int n);
      mdl_t m;
      m.own = 0; m.owner = 0; m.last = n - 1; m.bcnt = 0;
      return m;
   endfunction

   function automatic int mpick(input bit [15:0] r, input int last, input int n);
      for (int i = 1; i <= n; i++)
         if (r[(last + i) % n]) return (last + i) % n;
      return -1;
   endfunction

   function automatic bit mwrite(input mdl_t m, input bit [15:0] r, input bit wf);
      return m.own && r[m.owner] && !wf;
   endfunction

   function automatic mdl_t mstep(input mdl_t m, input bit [15:0] r, input bit wf,
                                  input int n, input int maxb);
      mdl_t nm = m;
      int   p;
      bit   w;
      if (!m.own) begin
         p = mpick(r, m.last, n);
         if (p >= 0) begin nm.own = 1; nm.owner = p; nm.bcnt = 0; end
      end else begin
         w = mwrite(m, r, wf);
         if (w) nm.bcnt = m.bcnt + 1;
         if ((w && m.bcnt == maxb - 1) || !r[m.owner]) begin
            nm.last = m.owner;
            nm.bcnt = 0;
            p = mpick(r, nm.last, n);
            if (p >= 0) nm.owner = p;
            else        nm.own = 0;
         end
      end
      return nm;
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      bit ew;
      ew = mwrite(ma, 16'(req), wfull);
      chk("A.winc", 32'(winc), 32'(ew));
      chk("A.busy", 32'(busy), 32'(ma.own));
      chk("A.gnt",  32'(gnt),  ma.own ? (32'd1 << ma.owner) : 32'd0);
      chk("A.ack",  32'(ack),  ew ? (32'd1 << ma.owner) : 32'd0);
      if (ew) begin
         chk("A.wsrc",  32'(wsrc),  32'(ma.owner));
         chk("A.wdata", 32'(wdata), (req_data >> (ma.owner * 8)) & 32'hff);
      end
      ew = mwrite(mb, 16'(reqb), wfull);
      chk("B.winc", 32'(winc_b), 32'(ew));
      chk("B.gnt",  32'(gntb),   mb.own ? (32'd1 << mb.owner) : 32'd0);
      chk("B.ack",  32'(ackb),   ew ? (32'd1 << mb.owner) : 32'd0);
      if (ew) begin
         chk("B.wsrc",  32'(wsrc_b),  32'(mb.owner));
         chk("B.wdata", 32'(wdata_b), (32'(req_datab) >> (mb.owner * 8)) & 32'hff);
      end
   endtask

   // One cycle: starts and ends at a falling edge.
   task automatic cyc(input logic [3:0] r, input logic [2:0] rb, input logic wf);
      req       = r;
      reqb      = rb;
      wfull     = wf;
      req_data  = 32'($urandom);
      req_datab = 24'($urandom);
      #1;
      check_all();
      @(posedge wclk);
      ma = mstep(ma, 16'(req), wfull, 4, 4);
      mb = mstep(mb, 16'(reqb), wfull, 3, 3);
      @(negedge wclk);
   endtask

   // Asynchronous reset in the low clock phase, outputs checked before any edge.
   task automatic do_reset();
      #2 wrst_n = 1'b0;
      #1;
      chk("rst.winc",  32'(winc),   32'd0);
      chk("rst.gnt",   32'(gnt),    32'd0);
      chk("rst.busy",  32'(busy),   32'd0);
      chk("rst.ack",   32'(ack),    32'd0);
      chk("rst.wsrc",  32'(wsrc),   32'd0);
      chk("rst.wdata", 32'(wdata),  32'd0);
      chk("rst.B.gnt", 32'(gntb),   32'd0);
      chk("rst.B.busy", 32'(busy_b), 32'd0);
      ma = mreset(4);
      mb = mreset(3);
      @(negedge wclk);
      wrst_n = 1'b1;
   endtask

   initial begin
      wrst_n    = 1'b1;
      req       = '0;
      reqb      = '0;
      wfull     = 1'b0;
      req_data  = 32'hA5C3_5A3C;
      req_datab = 24'h5A_A55A;
      do_reset();

      // Sole requester 0 streams continuously; instance B sees full contention.
      for (int i = 0; i < 12; i++) begin
         cyc(4'b0001, 3'b111, 1'b0);
         if (i >= 1) chk("single.winc", 32'(winc), 32'd1);
      end

      // Full contention on A.
      repeat (20) cyc(4'b1111, 3'b111, 1'b0);

      // Stall: owner 2 at bcnt=2, then wfull held 5 cycles.
      do_reset();
      repeat (3) cyc(4'b0100, 3'b100, 1'b0);
      for (int i = 0; i < 5; i++) begin
         cyc(4'b0100, 3'b100, 1'b1);
         chk("stall.gnt",  32'(gnt),  32'h4);
         chk("stall.winc", 32'(winc), 32'd0);
      end
      repeat (4) cyc(4'b0100, 3'b100, 1'b0);

      // Withdrawal: owner 1 leaves after one write while requester 3 waits.
      do_reset();
      cyc(4'b1010, 3'b010, 1'b0);
      cyc(4'b1010, 3'b010, 1'b0);
      cyc(4'b1000, 3'b001, 1'b0);
      chk("wd.gnt", 32'(gnt), 32'h8);
      repeat (2) cyc(4'b1000, 3'b001, 1'b0);

      // Reset mid-burst, then requester 0 must be granted first.
      repeat (3) cyc(4'b1111, 3'b111, 1'b0);
      do_reset();
      cyc(4'b1111, 3'b111, 1'b0);
      chk("post_rst.gnt", 32'(gnt), 32'h1);

      // Randomized traffic with occasional full and withdrawals.
      for (int i = 0; i < 400; i++)
         cyc(4'($urandom), 3'($urandom), ($urandom_range(0, 3) == 0));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
